// File: rtl/sr_bank_pkg.sv
// Shared definitions for the set/reset flip-flop bank: conflict modes and next-state rule.
package sr_bank_pkg;

  localparam int unsigned MODE_W       = 2;
  localparam int unsigned MODE_RST_DOM = 0;
  localparam int unsigned MODE_SET_DOM = 1;
  localparam int unsigned MODE_HOLD    = 2;
  localparam int unsigned MODE_TOGGLE  = 3;

  // Next value of one channel given its set/reset request, current value and s=r=1 policy.
  function automatic logic next_q(input logic s, input logic r, input logic q,
                                  input logic [MODE_W-1:0] mode);
    logic v;
    v = q;
    unique case ({s, r})
      2'b00: v = q;
      2'b01: v = 1'b0;
      2'b10: v = 1'b1;
      default: begin
        unique case (mode)
          MODE_W'(MODE_RST_DOM): v = 1'b0;
          MODE_W'(MODE_SET_DOM): v = 1'b1;
          MODE_W'(MODE_HOLD):    v = q;
          default:               v = ~q;
        endcase
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One clocked set/reset channel with registered complement and change flag.
module sr_ff_cell
  import sr_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s,
  input  logic              r,
  input  logic              rst_val,
  input  logic [MODE_W-1:0] mode,
  output logic              q,
  output logic              q_bar,
  output logic              changed
);

  logic w_q_next;
  logic r_q;
  logic r_q_bar;
  logic r_changed;

  // Resolve the request against the current state.
  always_comb begin
    w_q_next = next_q(s, r, r_q, mode);
  end

  // Channel state; the complement is registered alongside so it never lags q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= rst_val;
      r_q_bar   <= ~rst_val;
      r_changed <= 1'b0;
    end else if (en) begin
      r_q       <= w_q_next;
      r_q_bar   <= ~w_q_next;
      r_changed <= w_q_next ^ r_q;
    end else begin
      r_changed <= 1'b0;
    end
  end

  assign q       = r_q;
  assign q_bar   = r_q_bar;
  assign changed = r_changed;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of independent clocked set/reset flip-flops with a shared conflict monitor.
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter int unsigned      CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] changed,
  output logic             conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [MODE_W-1:0] MODE    = MODE_W'(CONFLICT_MODE);

  logic             w_conflict;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  // One cell per channel.
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    sr_ff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .s       (s[g]),
      .r       (r[g]),
      .rst_val (RESET_VALUE[g]),
      .mode    (MODE),
      .q       (q[g]),
      .q_bar   (q_bar[g]),
      .changed (changed[g])
    );
  end

  // A conflicting cycle is any enabled cycle where some channel sees s=r=1.
  always_comb begin
    w_conflict = en & (|(s & r));
  end

  // Sticky flag and saturating counter; a coincident clear is applied before counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (en) begin
      if (clr_conflict) begin
        r_sticky <= w_conflict;
        r_cnt    <= CNT_W'(w_conflict);
      end else if (w_conflict) begin
        r_sticky <= 1'b1;
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign conflict_sticky = r_sticky;
  assign conflict_cnt    = r_cnt;

endmodule
